// File: rtl/usr_pkg.sv
// Shared mode constants, FSM state type and mode-legality helper for universal_shift_register.
package usr_pkg;

    localparam logic [2:0] MODE_SHL = 3'd0;
    localparam logic [2:0] MODE_SHR = 3'd1;
    localparam logic [2:0] MODE_ROL = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_ASR = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    function automatic logic mode_is_valid(input logic [2:0] m);
        return (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Single-step shift/rotate function: purely combinational, zero latency, no flow control.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {serial_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised shift/rotate register with multi-cycle shift-by-N; load takes one edge, N steps take N cycles.
// No backpressure: load/start are accepted in IDLE only and are silently dropped while busy.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       mode_r, mode_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt, busy_nxt, done_nxt;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q         (q),
        .mode      (mode_r),
        .serial_in (serial_in),
        .next_q    (step_q),
        .out_bit   (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mode_r     <= MODE_SHL;
            q          <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mode_r     <= mode_nxt;
            q          <= q_nxt;
            serial_out <= so_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_r;
        q_nxt     = q;
        so_nxt    = serial_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    q_nxt = d;
                end else if (start) begin
                    if (amount == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        mode_nxt  = mode;
                        cnt_nxt   = amount;
                        state_nxt = ST_SHIFT;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // Reserved modes still count down, but q and serial_out hold.
                if (mode_is_valid(mode_r)) begin
                    q_nxt  = step_q;
                    so_nxt = step_out;
                end
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=8): expected outputs queued per driven cycle, popped after each edge.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    typedef struct {
        string      tag;
        logic [7:0] q_e;
        logic       so_e;
        logic       busy_e;
        logic       done_e;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] ror_q  [0:7];
    logic       ror_so [0:7];

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .d          (d),
        .start      (start),
        .mode       (mode),
        .amount     (amount),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] eq, input logic es,
                              input logic eb, input logic ed);
        exp_t e;
        e.tag    = tag;
        e.q_e    = eq;
        e.so_e   = es;
        e.busy_e = eb;
        e.done_e = ed;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_q"},    32'(q),          32'(e.q_e));
            check({e.tag, "_so"},   32'(serial_out), 32'(e.so_e));
            check({e.tag, "_busy"}, 32'(busy),       32'(e.busy_e));
            check({e.tag, "_done"}, 32'(done),       32'(e.done_e));
        end
    endtask

    // Queue the outputs expected after the coming edge, then take the edge and compare.
    task automatic step(input string tag, input logic [7:0] eq, input logic es,
                        input logic eb, input logic ed);
        expect_out(tag, eq, es, eb, ed);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    initial begin
        ror_q  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        ror_so = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; load = 1'b0; d = '0; start = 1'b0;
        mode = 3'd0; amount = '0; serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        pop_cmp();
        rst_n = 1'b1;

        load = 1'b1; d = 8'hB4;
        step("load_b4", 8'hB4, 1'b0, 1'b0, 1'b0);
        d = 8'hD0;
        step("load_d0", 8'hD0, 1'b0, 1'b0, 1'b0);
        load = 1'b0;

        // SHL by 3; mode/amount are scrambled mid-operation and must be ignored.
        start = 1'b1; mode = 3'd0; amount = 4'd3; serial_in = 1'b0;
        step("shl_start", 8'hD0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = 3'd1; amount = 4'd7;
        step("shl_1", 8'hA0, 1'b1, 1'b1, 1'b0);
        step("shl_2", 8'h40, 1'b1, 1'b1, 1'b0);
        step("shl_3", 8'h80, 1'b0, 1'b0, 1'b1);
        step("shl_idle", 8'h80, 1'b0, 1'b0, 1'b0);

        load = 1'b1; d = 8'h81;
        step("load_81", 8'h81, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        start = 1'b1; mode = 3'd3; amount = 4'd8;
        step("ror_start", 8'h81, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load  = (i == 1);
            start = (i == 1);
            d     = 8'hFF;
            step($sformatf("ror_%0d", i), ror_q[i], ror_so[i], (i < 7), (i == 7));
        end
        load = 1'b0; start = 1'b0;
        step("ror_idle", 8'h81, 1'b1, 1'b0, 1'b0);

        load = 1'b1; d = 8'h90;
        step("load_90", 8'h90, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        start = 1'b1; mode = 3'd4; amount = 4'd2;
        step("asr_start", 8'h90, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("asr_1", 8'hC8, 1'b0, 1'b1, 1'b0);
        step("asr_2", 8'hE4, 1'b0, 1'b0, 1'b1);

        start = 1'b1; mode = 3'd0; amount = 4'd0; serial_in = 1'b1;
        step("zero_start", 8'hE4, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        step("zero_idle", 8'hE4, 1'b0, 1'b0, 1'b0);

        // Second start is raised while the first operation's done is high.
        start = 1'b1; mode = 3'd0; amount = 4'd1; serial_in = 1'b1;
        step("b2b_a_start", 8'hE4, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step("b2b_a_done", 8'hC9, 1'b1, 1'b0, 1'b1);
        start = 1'b1; serial_in = 1'b0;
        step("b2b_b_start", 8'hC9, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("b2b_b_done", 8'h92, 1'b1, 1'b0, 1'b1);
        step("b2b_idle", 8'h92, 1'b1, 1'b0, 1'b0);

        start = 1'b1; mode = 3'd1; amount = 4'd5; serial_in = 1'b0;
        step("shr_start", 8'h92, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("shr_1", 8'h49, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        pop_cmp();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("post_rst_%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the fixed 4-bit left shift register. It has:
- a WIDTH-bit datapath,
- selectable shift, rotate and arithmetic modes,
- serial in/out,
- a multi-cycle shift-by-N operation controlled by a start/busy/done handshake.

It sits in the same datapath utility set and serves as the general shifter for serialisers and bit-manipulation blocks.

## Interface
- WIDTH, default 8: register width in bits; legal range is 2 or more.
- CNT_W, default $clog2(WIDTH+1): width of the amount port. It is a derived localparam and is not overridden.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  parallel load request; sampled in IDLE only.
- d  in  WIDTH  parallel load data.
- start  in  1  begin a shift-by-amount operation; sampled in IDLE only.
- mode  in  3  operation select, latched at start.
- amount  in  CNT_W  number of single-bit steps, latched at start.
- serial_in  in  1  fill bit for SHL/SHR; sampled live on every step.
- q  out  WIDTH  register contents.
- serial_out  out  1  last bit shifted or rotated out.
- busy  out  1  an operation is in progress.
- done  out  1  single-cycle pulse marking the end of an operation.

## Operation
- States: IDLE and SHIFT.
- Mode encoding:
  - 0 SHL: q <= {q[W-2:0], serial_in}; out bit is q[W-1].
  - 1 SHR: q <= {serial_in, q[W-1:1]}; out bit is q[0].
  - 2 ROL, 3 ROR: rotate by one; the out bit is the wrapped bit.
  - 4 ASR: fill with q[W-1]; out bit is q[0].
  - 5-7 reserved: q holds each step, but the counter, busy and done behave normally.
- IDLE:
  - load=1: q <= d. load takes priority over start; start is dropped that cycle.
  - start=1, amount=0: no state change; done pulses; busy stays 0.
  - start=1, amount>0: latch mode and amount, go to SHIFT.
- SHIFT:
  - One step per cycle; count decrements each step.
  - After the step that takes count to 0: return to IDLE and pulse done.
- load and start are ignored while busy. mode and amount changes mid-operation have no effect.
- serial_out updates only on a step and holds otherwise.
- amount > WIDTH is legal and is executed literally, e.g. SHL by 15 with serial_in=0 gives 0.
- Reset:
  - Values: q=0, serial_out=0, busy=0, done=0, state IDLE.
  - Reset takes effect immediately, including mid-operation.
  - An aborted operation never produces done.

## Timing
- start sampled at edge k with amount=N>0:
  - Steps occur on edges k+1 through k+N.
  - busy is 1 from edge k to edge k+N: exactly N cycles.
  - done is 1 from edge k+N to edge k+N+1.
- Back-to-back operations: start may be asserted in the cycle done is high. It is sampled at edge k+N+1, giving a one-cycle gap between operations.
- amount=0: done is 1 for the cycle after edge k.
- Load latency is one edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package usr_pkg holds:
  - the mode constants: MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR;
  - the state enum: ST_IDLE, ST_SHIFT.
- Sub-module usr_step: combinational single-step function with ports q, mode, serial_in -> next_q, out_bit, parametrised by WIDTH.
- The top level holds the FSM, the counter and the registers.

## Test plan
All scenarios use WIDTH=8.
- Reset and load: hold rst_n low -> q=00, busy=0, done=0, serial_out=0. Release, then load d=B4 -> q=B4 after one edge.
- SHL: q=D0, start SHL amount=3, serial_in=0.
  - q steps D0 -> A0 -> 40 -> 80.
  - serial_out steps 1, 1, 0.
  - busy is high for 3 cycles, then done for 1 cycle.
- ROR and ASR:
  - q=81, ROR amount=8 -> q=81 after 8 busy cycles.
  - q=90, ASR amount=2 -> q steps C8 then E4.
- Zero amount and ignored inputs:
  - start with amount=0 -> done next cycle, busy stays 0, q unchanged.
  - load d=FF during busy -> ignored; q is unaffected.
- Reset mid-operation: assert rst_n low in cycle 2 of SHR amount=5 -> q=00 and busy=0 immediately; no done after release.
- Back-to-back: start SHL amount=1 in the done cycle of a previous operation -> second operation completes correctly, with busy re-asserting after a one-cycle gap.
